// File: rtl/jtframe_frac_cen.sv
// jtframe_frac_cen
// Fractional clock-enable generator. A phase accumulator produces a base
// enable pulse train (cen[0]) averaging step/lim of the clk rate. Binary
// divided enables cen[k] = base / 2^k are phase-locked to the base pulses.
// step/lim can be reprogrammed at run time; bad writes and corrupt
// accumulator states raise a sticky error flag.
//
// Ports:
//   clk       system clock (single domain)
//   rst       synchronous active-high reset
//   cfg_we    one-cycle strobe that loads cfg_step/cfg_lim
//   cfg_step  new step value
//   cfg_lim   new limit value
//   pause     freezes the accumulator and suppresses all enables
//   err_clr   clears err (a simultaneous error set wins)
//   cen       one-cycle enable pulses, cen[k] = base rate / 2^k
//   err       sticky error flag
//   step      active step value (readback)
//   lim       active limit value (readback)
module jtframe_frac_cen #(
    parameter int W     = 16,
    parameter int NDIV  = 3,
    parameter int STEP0 = 105,
    parameter int LIM0  = 1408
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [W-1:0]    cfg_step,
    input  logic [W-1:0]    cfg_lim,
    input  logic            pause,
    input  logic            err_clr,
    output logic [NDIV-1:0] cen,
    output logic            err,
    output logic [W-1:0]    step,
    output logic [W-1:0]    lim
);

    // With NDIV=1 there is no divider; an unused 1-bit register keeps the code uniform.
    localparam int DW = (NDIV > 1) ? (NDIV - 1) : 1;

    logic [W-1:0]    cnt_r,  cnt_nxt_s;
    logic [DW-1:0]   div_r,  div_nxt_s;
    logic [W-1:0]    step_r, step_nxt_s;
    logic [W-1:0]    lim_r,  lim_nxt_s;
    logic            err_r,  err_nxt_s;
    logic [NDIV-1:0] cen_r,  cen_nxt_s;
    logic            err_set_s;
    logic            run_s;

    // All comparisons are done one bit wider so cnt+step never wraps.
    logic [W:0] sum_s;
    logic [W:0] lim_x_s;
    logic [W:0] lim_plus_step_s;
    logic [W:0] diff_s;
    logic       corrupt_s;
    logic       cfg_valid_s;

    assign sum_s           = {1'b0, cnt_r} + {1'b0, step_r};
    assign lim_x_s         = {1'b0, lim_r};
    assign lim_plus_step_s = {1'b0, lim_r} + {1'b0, step_r};
    assign diff_s          = sum_s - lim_x_s;
    // Legitimate operation keeps cnt below lim; anything at or past lim+step
    // can only come from an upset and is treated as corruption.
    assign corrupt_s       = ({1'b0, cnt_r} >= lim_plus_step_s);
    assign cfg_valid_s     = (cfg_step != {W{1'b0}}) && (cfg_step <= cfg_lim);

    // Next-state logic: config write > pause > corruption recovery > accumulate.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        div_nxt_s  = div_r;
        step_nxt_s = step_r;
        lim_nxt_s  = lim_r;
        cen_nxt_s  = {NDIV{1'b0}};
        err_set_s  = 1'b0;
        run_s      = 1'b1;
        if (cfg_we && cfg_valid_s) begin
            step_nxt_s = cfg_step;
            lim_nxt_s  = cfg_lim;
            cnt_nxt_s  = {W{1'b0}};
            div_nxt_s  = {DW{1'b0}};
        end else begin
            // A rejected write is flagged but otherwise behaves like a normal cycle.
            if (cfg_we) begin
                err_set_s = 1'b1;
            end else begin
                err_set_s = 1'b0;
            end
            if (pause) begin
                cnt_nxt_s = cnt_r;
                div_nxt_s = div_r;
            end else if (corrupt_s) begin
                cnt_nxt_s = {W{1'b0}};
                div_nxt_s = {DW{1'b0}};
                err_set_s = 1'b1;
            end else if (sum_s >= lim_x_s) begin
                cnt_nxt_s    = diff_s[W-1:0];
                cen_nxt_s[0] = 1'b1;
                div_nxt_s    = div_r + {{(DW-1){1'b0}}, 1'b1};
                // cen[k] fires when the low k divider bits are all ones, so
                // the 2^k-th base pulse of every group carries cen[k].
                for (int k = 1; k < NDIV; k++) begin
                    run_s        = run_s & div_r[k-1];
                    cen_nxt_s[k] = run_s;
                end
            end else begin
                cnt_nxt_s = sum_s[W-1:0];
            end
        end
        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {W{1'b0}};
            div_r  <= {DW{1'b0}};
            step_r <= W'(STEP0);
            lim_r  <= W'(LIM0);
            err_r  <= 1'b0;
            cen_r  <= {NDIV{1'b0}};
        end else begin
            cnt_r  <= cnt_nxt_s;
            div_r  <= div_nxt_s;
            step_r <= step_nxt_s;
            lim_r  <= lim_nxt_s;
            err_r  <= err_nxt_s;
            cen_r  <= cen_nxt_s;
        end
    end

    assign cen  = cen_r;
    assign err  = err_r;
    assign step = step_r;
    assign lim  = lim_r;

endmodule

// File: doc/jtframe_frac_cen.md
# jtframe_frac_cen

Parametrised fractional clock-enable generator: produces a base enable pulse train averaging `step/lim` of the system clock rate, plus binary-divided enables derived from it. The base pulse is phase-locked to the divided pulses. Step and limit are reprogrammable at run time, with validation, pause and self-recovery. Intended to drive `cen`/`cen_p1`-style inputs of sound and CPU cores from a single fast system clock, such as 48 MHz.

## Interface
Parameters:
- `W`, 16, width of step, limit and phase accumulator.
- `NDIV`, 3, number of enable outputs. `cen[0]` is the base rate; `cen[k]` is the base rate divided by 2^k. Range 1..8.
- `STEP0`, 105, step value after reset.
- `LIM0`, 1408, limit value after reset.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  one-cycle strobe that loads `cfg_step`/`cfg_lim`.
- `cfg_step`  in  W  new step value.
- `cfg_lim`  in  W  new limit value.
- `pause`  in  1  while high, holds the accumulator and suppresses all enables.
- `err_clr`  in  1  clears `err`.
- `cen`  out  NDIV  one-cycle enable pulses.
- `err`  out  1  sticky error flag.
- `step`  out  W  active step value (readback).
- `lim`  out  W  active limit value (readback).

## Operation
- State:
  - accumulator `cnt[W-1:0]`;
  - divider counter `div[NDIV-2:0]` (absent when NDIV=1);
  - `step`, `lim`, `err`.
- Arithmetic is carried out in W+1 bits: `nxt = cnt + step`. No W-bit wrap is allowed.
- Normal cycle, with `rst`, `cfg_we` and `pause` all low:
  - If `cnt >= lim + step` (corrupt state): load `cnt` and `div` with 0, set `err`, all `cen` low.
  - Else if `nxt >= lim`:
    - load `cnt` with `nxt - lim`;
    - assert `cen[0]`;
    - for each k≥1, assert `cen[k]` iff `div[k-1:0]` is all ones;
    - `div` increments modulo 2^(NDIV-1).
  - Else load `cnt` with `nxt`; all `cen` low.
- Divided-enable phase follows from the rule above:
  - `cen[1]` fires on the 2nd, 4th, … base pulse after reset or config.
  - `cen[k]` fires on every 2^k-th base pulse.
  - Every `cen[k]` pulse coincides with a `cen[0]` pulse.
- Configuration on `cfg_we`:
  - Validity: the write is valid iff `cfg_step != 0` and `cfg_step <= cfg_lim`.
  - Valid write: load `step`/`lim`, clear `cnt` and `div`, all `cen` low that cycle.
  - Invalid write: `step`/`lim`/`cnt`/`div` unchanged, operation continues as a normal cycle, and `err` is set.
- `step == lim` is legal: `cen[0]` then fires every cycle.
- `pause` high: `cnt`/`div` hold and `cen` is all low. Resuming continues the exact phase; no pulse is lost or duplicated relative to unpaused cycles.
- Priority: `rst` > `cfg_we` > `pause` > normal.
  - `cfg_we` while paused is still applied.
  - `err` set wins over `err_clr` in the same cycle.
- `err` clears only on `rst` or `err_clr`.

## Timing
- All outputs are registered.
  - `cen` is updated on the same edge as `cnt`.
  - Each pulse is exactly one `clk` cycle wide.
- Reset values:
  - `cen` = 0, `err` = 0, `cnt` = 0, `div` = 0;
  - `step` = STEP0, `lim` = LIM0.
- After `rst` deasserts, the first `cen[0]` appears after ceil(lim/step) active cycles. For example, step=1, lim=2 gives the first pulse on the 2nd edge after reset release.
- Config latency:
  - New `step`/`lim` are visible on readback the cycle after `cfg_we`.
  - The new rate applies from the following cycle, with phase starting from `cnt` = 0.
- Pulse spacing on `cen[0]` is always floor(lim/step) or ceil(lim/step) cycles. Over any lim·m active cycles starting from `cnt` = 0 there are exactly step·m pulses.
- Reset mid-operation: on the edge where `rst` is sampled high, all state returns to reset values and no pulse is emitted.

## Test plan
- Reset defaults, NDIV=3, 14080 active cycles from reset:
  - exactly 1050 `cen[0]`, 525 `cen[1]`, 262 `cen[2]` pulses;
  - `cen[0]` gaps only 13 or 14 cycles;
  - every `cen[1]`/`cen[2]` pulse coincides with a `cen[0]` pulse.
- Write step=1, lim=2:
  - `cen[0]` on every 2nd cycle, first pulse 2 cycles after the write takes effect;
  - `cen[1]` every 4 cycles;
  - `cen[2]` every 8 cycles.
- Write step=4, lim=4:
  - `cen[0]` high every cycle, `cen[1]` alternates, `cen[2]` every 4th cycle;
  - `err` stays 0.
- Invalid writes:
  - step=0, lim=100 → `err`=1, readback still 105/1408, pulse train uninterrupted;
  - step=200, lim=100 → same result;
  - `err_clr` → `err`=0.
- Pause:
  - Assert `pause` for 50 cycles mid-stream → no pulses during the pause.
  - Pulse count over the unpaused cycles equals an unpaused reference run, for the same number of active cycles.
- Reset and corrupt state:
  - Assert `rst` for 1 cycle mid-stream → `cen` = 0 and readback 105/1408 next cycle, then the first-pulse timing matches a power-on reset.
  - Force `cnt` ≥ lim+step → `cnt` = 0 and `err` = 1 on the next edge.
